// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine order controller.
// Holds the controller state enum, coin encodings/values, the credit width
// and its ceiling, plus a coin decode helper.
package vend_pkg;

    localparam int unsigned MONEY_W   = 4;
    localparam int unsigned MONEY_MAX = 15;
    localparam int unsigned CODE_W    = 2;
    localparam int unsigned COUNT_W   = 3;
    localparam int unsigned TIMER_W   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        VEND    = 2'd3
    } state_e;

    localparam logic [1:0] COIN_1   = 2'b00;
    localparam logic [1:0] COIN_2   = 2'b01;
    localparam logic [1:0] COIN_5   = 2'b10;
    localparam logic [1:0] COIN_BAD = 2'b11;

    localparam logic [MONEY_W-1:0] VAL_1 = MONEY_W'(1);
    localparam logic [MONEY_W-1:0] VAL_2 = MONEY_W'(2);
    localparam logic [MONEY_W-1:0] VAL_5 = MONEY_W'(5);

    // Face value of a coin; the invalid encoding is worth nothing.
    function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] coin_type);
        case (coin_type)
            COIN_1:  coin_value = VAL_1;
            COIN_2:  coin_value = VAL_2;
            COIN_5:  coin_value = VAL_5;
            default: coin_value = '0;
        endcase
    endfunction

endpackage

// File: rtl/vend_idle_timer.sv
// Idle-cycle counter for the COLLECT state.
// Ports: clk, rst_n (async active-low), clear (restart count), enable (count
// this cycle), expired (this is the TIMEOUT-th consecutive idle cycle).
module vend_idle_timer
    import vend_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Count holds the number of idle cycles already completed, so the
    // TIMEOUT-th idle cycle is the one where the count equals TIMEOUT-1.
    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    // Next count: restart on clear, otherwise advance and hold at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/vend_order_ctrl.sv
// Sequential front end of the vending machine: collects coins and a selection,
// drives the combinational price checker (code/count/money), samples its
// verdict (posibility/remaining) and issues dispense, change, reject and fail
// pulses. Inputs: clk, rst_n, coin_valid/coin_type, sel_valid/sel_code/
// sel_count, cancel, posibility, remaining. Outputs (all registered): code,
// count, money, dispense/dispense_code/dispense_count, change_valid/change,
// coin_reject, vend_fail, busy.
module vend_order_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       sel_valid,
    input  logic [1:0] sel_code,
    input  logic [2:0] sel_count,
    input  logic       cancel,
    input  logic       posibility,
    input  logic [3:0] remaining,
    output logic [1:0] code,
    output logic [2:0] count,
    output logic [3:0] money,
    output logic       dispense,
    output logic [1:0] dispense_code,
    output logic [2:0] dispense_count,
    output logic       change_valid,
    output logic [3:0] change,
    output logic       coin_reject,
    output logic       vend_fail,
    output logic       busy
);

    localparam int unsigned SUM_W = MONEY_W + 1;

    state_e               state_q, state_d;
    logic [MONEY_W-1:0]   money_q, money_d;
    logic [CODE_W-1:0]    code_q, code_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 dispense_q, dispense_d;
    logic [CODE_W-1:0]    dispense_code_q, dispense_code_d;
    logic [COUNT_W-1:0]   dispense_count_q, dispense_count_d;
    logic                 change_valid_q, change_valid_d;
    logic [MONEY_W-1:0]   change_q, change_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 vend_fail_q, vend_fail_d;
    logic                 busy_q, busy_d;

    logic                 coin_ok, coin_acc, sel_acc, expired, timer_clear, timer_en;
    logic [SUM_W-1:0]     coin_sum;

    // Coin is acceptable if its encoding is valid and credit stays within range.
    assign coin_sum = SUM_W'(money_q) + SUM_W'(coin_value(coin_type));
    assign coin_ok  = (coin_type != COIN_BAD) && (coin_sum <= SUM_W'(MONEY_MAX));

    // Idle count only runs in COLLECT and restarts on any accepted action.
    assign timer_en    = (state_q == COLLECT);
    assign timer_clear = (state_q != COLLECT) || coin_acc || sel_acc;

    vend_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (expired)
    );

    // Next-state and registered-output logic; priority cancel/timeout > select > coin.
    always_comb begin
        state_d          = state_q;
        money_d          = money_q;
        code_d           = code_q;
        count_d          = count_q;
        dispense_d       = 1'b0;
        dispense_code_d  = '0;
        dispense_count_d = '0;
        change_valid_d   = 1'b0;
        change_d         = '0;
        vend_fail_d      = 1'b0;
        coin_acc         = 1'b0;
        sel_acc          = 1'b0;

        case (state_q)
            IDLE, COLLECT: begin
                if ((state_q == COLLECT) && (cancel || expired)) begin
                    change_valid_d = 1'b1;
                    change_d       = money_q;
                    money_d        = '0;
                    state_d        = IDLE;
                end else if ((state_q == COLLECT) && sel_valid) begin
                    code_d  = sel_code;
                    count_d = sel_count;
                    sel_acc = 1'b1;
                    state_d = CHECK;
                end else if (coin_valid && coin_ok) begin
                    coin_acc = 1'b1;
                    money_d  = coin_sum[MONEY_W-1:0];
                    state_d  = COLLECT;
                end
            end
            CHECK: begin
                if (posibility) begin
                    dispense_d       = 1'b1;
                    dispense_code_d  = code_q;
                    dispense_count_d = count_q;
                    change_valid_d   = 1'b1;
                    change_d         = remaining;
                    state_d          = VEND;
                end else begin
                    vend_fail_d = 1'b1;
                    state_d     = COLLECT;
                end
            end
            VEND: begin
                money_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Any coin not taken above (bad, overflowing, outranked or mid-decision) goes back.
        coin_reject_d = coin_valid && !coin_acc;
        busy_d        = (state_d == CHECK) || (state_d == VEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            money_q          <= '0;
            code_q           <= '0;
            count_q          <= '0;
            dispense_q       <= 1'b0;
            dispense_code_q  <= '0;
            dispense_count_q <= '0;
            change_valid_q   <= 1'b0;
            change_q         <= '0;
            coin_reject_q    <= 1'b0;
            vend_fail_q      <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            money_q          <= money_d;
            code_q           <= code_d;
            count_q          <= count_d;
            dispense_q       <= dispense_d;
            dispense_code_q  <= dispense_code_d;
            dispense_count_q <= dispense_count_d;
            change_valid_q   <= change_valid_d;
            change_q         <= change_d;
            coin_reject_q    <= coin_reject_d;
            vend_fail_q      <= vend_fail_d;
            busy_q           <= busy_d;
        end
    end

    assign code           = code_q;
    assign count          = count_q;
    assign money          = money_q;
    assign dispense       = dispense_q;
    assign dispense_code  = dispense_code_q;
    assign dispense_count = dispense_count_q;
    assign change_valid   = change_valid_q;
    assign change         = change_q;
    assign coin_reject    = coin_reject_q;
    assign vend_fail      = vend_fail_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_vend_order_ctrl.sv
// Self-checking bench for vend_order_ctrl. Expected pulse events are queued
// as stimulus is driven and popped by a monitor whenever the DUT pulses;
// each scenario task also checks cycle timing and state inline.
module tb_vend_order_ctrl;
    import vend_pkg::*;

    localparam int unsigned TMO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_code = 2'b00;
    logic [2:0] sel_count = 3'b000;
    logic       cancel = 1'b0;
    logic       stub_pos = 1'b0;
    logic [3:0] stub_rem = 4'd0;
    logic [1:0] code;
    logic [2:0] count;
    logic [3:0] money;
    logic       dispense;
    logic [1:0] dispense_code;
    logic [2:0] dispense_count;
    logic       change_valid;
    logic [3:0] change;
    logic       coin_reject;
    logic       vend_fail;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       disp;
        logic [1:0] dcode;
        logic [2:0] dcnt;
        logic       chv;
        logic [3:0] chg;
        logic       rej;
        logic       fail;
    } ev_t;

    ev_t exp_q[$];

    vend_order_ctrl #(.TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .coin_valid     (coin_valid),
        .coin_type      (coin_type),
        .sel_valid      (sel_valid),
        .sel_code       (sel_code),
        .sel_count      (sel_count),
        .cancel         (cancel),
        .posibility     (stub_pos),
        .remaining      (stub_rem),
        .code           (code),
        .count          (count),
        .money          (money),
        .dispense       (dispense),
        .dispense_code  (dispense_code),
        .dispense_count (dispense_count),
        .change_valid   (change_valid),
        .change         (change),
        .coin_reject    (coin_reject),
        .vend_fail      (vend_fail),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every pulse cycle must match the next queued event.
    always @(negedge clk) begin
        ev_t got, want;
        if (dispense || change_valid || coin_reject || vend_fail) begin
            got = {dispense, dispense_code, dispense_count, change_valid, change, coin_reject, vend_fail};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event @%0t: got %h, expected no event", $time, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL event @%0t: got %h, expected %h", $time, got, want);
                end
            end
        end
    end

    function automatic void push_ev(logic disp, logic [1:0] dc, logic [2:0] dn,
                                    logic chv, logic [3:0] chg, logic rej, logic fl);
        ev_t e;
        e = {disp, dc, dn, chv, chg, rej, fl};
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        tick();
        coin_valid = 1'b0;
        coin_type  = 2'b00;
    endtask

    task automatic drive_sel(input logic [1:0] c, input logic [2:0] n);
        sel_valid = 1'b1;
        sel_code  = c;
        sel_count = n;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({code, count, money, dispense, dispense_code, dispense_count, change_valid, change, coin_reject, vend_fail, busy} !== 27'd0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
        end
        n_cmp++;
        if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, expected %0d", dut.state_q, IDLE); end
        rst_n = 1'b1;
        tick();
        drive_coin(COIN_5);
        drive_coin(COIN_2);
        n_cmp++;
        if (money !== 4'd7) begin n_fail++; $display("FAIL reset_pre_money: got %0d, expected 7", money); end
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (money !== 4'd0 || dut.state_q !== IDLE || change_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got money=%0d state=%0d chv=%0b, expected 0/IDLE/0", money, dut.state_q, change_valid);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_vend();
        drive_coin(COIN_5);
        drive_coin(COIN_5);
        drive_coin(COIN_5);
        n_cmp++;
        if (money !== 4'd15) begin n_fail++; $display("FAIL vend_money15: got %0d, expected 15", money); end
        stub_pos = 1'b1;
        stub_rem = 4'd3;
        push_ev(1'b1, 2'b01, 3'b001, 1'b1, 4'd3, 1'b0, 1'b0);
        drive_sel(2'b01, 3'b001);
        n_cmp++;
        if (busy !== 1'b1 || code !== 2'b01 || count !== 3'b001 || dut.state_q !== CHECK) begin
            n_fail++; $display("FAIL vend_check: got busy=%0b code=%0d count=%0d state=%0d, expected 1/1/1/CHECK", busy, code, count, dut.state_q);
        end
        tick();
        n_cmp++;
        if (dispense !== 1'b1 || dispense_code !== 2'b01 || dispense_count !== 3'b001 || change_valid !== 1'b1 || change !== 4'd3) begin
            n_fail++; $display("FAIL vend_dispense: got disp=%0b dc=%0d dn=%0d chv=%0b chg=%0d, expected 1/1/1/1/3", dispense, dispense_code, dispense_count, change_valid, change);
        end
        tick();
        n_cmp++;
        if (money !== 4'd0 || dut.state_q !== IDLE || busy !== 1'b0 || dispense !== 1'b0) begin
            n_fail++; $display("FAIL vend_after: got money=%0d state=%0d busy=%0b, expected 0/IDLE/0", money, dut.state_q, busy);
        end
    endtask

    task automatic test_unaffordable();
        drive_coin(COIN_2);
        drive_coin(COIN_2);
        stub_pos = 1'b0;
        stub_rem = 4'd0;
        push_ev(1'b0, 2'b00, 3'b000, 1'b0, 4'd0, 1'b0, 1'b1);
        drive_sel(2'b10, 3'b011);
        tick();
        n_cmp++;
        if (vend_fail !== 1'b1 || money !== 4'd4 || dut.state_q !== COLLECT || dispense !== 1'b0) begin
            n_fail++; $display("FAIL unaff_fail: got fail=%0b money=%0d state=%0d, expected 1/4/COLLECT", vend_fail, money, dut.state_q);
        end
        push_ev(1'b0, 2'b00, 3'b000, 1'b1, 4'd4, 1'b0, 1'b0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n_cmp++;
        if (change_valid !== 1'b1 || change !== 4'd4 || money !== 4'd0) begin
            n_fail++; $display("FAIL unaff_refund: got chv=%0b chg=%0d money=%0d, expected 1/4/0", change_valid, change, money);
        end
    endtask

    task automatic test_coins();
        drive_coin(COIN_5);
        drive_coin(COIN_5);
        drive_coin(COIN_2);
        drive_coin(COIN_2);
        push_ev(1'b0, 2'b00, 3'b000, 1'b0, 4'd0, 1'b1, 1'b0);
        drive_coin(COIN_2);
        n_cmp++;
        if (coin_reject !== 1'b1 || money !== 4'd14) begin
            n_fail++; $display("FAIL coin_overflow: got rej=%0b money=%0d, expected 1/14", coin_reject, money);
        end
        push_ev(1'b0, 2'b00, 3'b000, 1'b0, 4'd0, 1'b1, 1'b0);
        drive_coin(COIN_BAD);
        n_cmp++;
        if (coin_reject !== 1'b1 || money !== 4'd14) begin
            n_fail++; $display("FAIL coin_invalid: got rej=%0b money=%0d, expected 1/14", coin_reject, money);
        end
        stub_pos = 1'b0;
        push_ev(1'b0, 2'b00, 3'b000, 1'b0, 4'd0, 1'b1, 1'b1);
        drive_sel(2'b11, 3'b111);
        drive_coin(COIN_1);
        n_cmp++;
        if (coin_reject !== 1'b1 || vend_fail !== 1'b1 || money !== 4'd14) begin
            n_fail++; $display("FAIL coin_in_check: got rej=%0b fail=%0b money=%0d, expected 1/1/14", coin_reject, vend_fail, money);
        end
        push_ev(1'b0, 2'b00, 3'b000, 1'b1, 4'd14, 1'b0, 1'b0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic test_cancel();
        drive_coin(COIN_5);
        drive_coin(COIN_2);
        push_ev(1'b0, 2'b00, 3'b000, 1'b1, 4'd7, 1'b0, 1'b0);
        cancel = 1'b1;
        drive_sel(2'b11, 3'b010);
        cancel = 1'b0;
        n_cmp++;
        if (change_valid !== 1'b1 || change !== 4'd7 || busy !== 1'b0 || dut.state_q !== IDLE) begin
            n_fail++; $display("FAIL cancel_vs_sel: got chv=%0b chg=%0d busy=%0b state=%0d, expected 1/7/0/IDLE", change_valid, change, busy, dut.state_q);
        end
        drive_coin(COIN_5);
        stub_pos = 1'b1;
        stub_rem = 4'd2;
        push_ev(1'b1, 2'b10, 3'b100, 1'b1, 4'd2, 1'b0, 1'b0);
        drive_sel(2'b10, 3'b100);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n_cmp++;
        if (dispense !== 1'b1 || change !== 4'd2 || dut.state_q !== VEND) begin
            n_fail++; $display("FAIL cancel_in_check: got disp=%0b chg=%0d state=%0d, expected 1/2/VEND", dispense, change, dut.state_q);
        end
        tick();
        n_cmp++;
        if (money !== 4'd0 || dut.state_q !== IDLE) begin
            n_fail++; $display("FAIL cancel_in_check_after: got money=%0d state=%0d, expected 0/IDLE", money, dut.state_q);
        end
    endtask

    task automatic test_timeout();
        push_ev(1'b0, 2'b00, 3'b000, 1'b1, 4'd1, 1'b0, 1'b0);
        drive_coin(COIN_1);
        repeat (TMO - 1) tick();
        n_cmp++;
        if (change_valid !== 1'b0 || dut.state_q !== COLLECT) begin
            n_fail++; $display("FAIL timeout_early: got chv=%0b state=%0d, expected 0/COLLECT", change_valid, dut.state_q);
        end
        tick();
        n_cmp++;
        if (change_valid !== 1'b1 || change !== 4'd1 || dut.state_q !== IDLE) begin
            n_fail++; $display("FAIL timeout_fire: got chv=%0b chg=%0d state=%0d, expected 1/1/IDLE", change_valid, change, dut.state_q);
        end
        drive_coin(COIN_1);
        repeat (TMO - 2) tick();
        drive_coin(COIN_1);
        push_ev(1'b0, 2'b00, 3'b000, 1'b1, 4'd2, 1'b0, 1'b0);
        repeat (TMO - 1) tick();
        n_cmp++;
        if (change_valid !== 1'b0 || dut.state_q !== COLLECT || money !== 4'd2) begin
            n_fail++; $display("FAIL timeout_restart_early: got chv=%0b state=%0d money=%0d, expected 0/COLLECT/2", change_valid, dut.state_q, money);
        end
        tick();
        n_cmp++;
        if (change_valid !== 1'b1 || change !== 4'd2 || dut.state_q !== IDLE) begin
            n_fail++; $display("FAIL timeout_restart_fire: got chv=%0b chg=%0d state=%0d, expected 1/2/IDLE", change_valid, change, dut.state_q);
        end
    endtask

    initial begin
        test_reset();
        test_vend();
        test_unaffordable();
        test_coins();
        test_cancel();
        test_timeout();
        repeat (3) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d pending events, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
